// File: rtl/spdu_xbar_if.sv
// Bus interface for spdu_xbar: input lanes, config port and output lanes.
// master drives lanes/config, slave is the crossbar.
interface spdu_xbar_if #(
  parameter int unsigned NUM_IN  = 4,
  parameter int unsigned NUM_OUT = 4,
  parameter int unsigned WIDTH   = 1
);
  localparam int unsigned SEL_W  = $clog2(NUM_IN);
  localparam int unsigned PORT_W = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

  logic [NUM_IN*WIDTH-1:0]  in_data;
  logic [NUM_IN-1:0]        in_valid;
  logic                     cfg_we;
  logic [PORT_W-1:0]        cfg_port;
  logic [SEL_W-1:0]         cfg_sel;
  logic                     cfg_commit;
  logic                     cfg_err;
  logic [NUM_OUT*WIDTH-1:0] out_data;
  logic [NUM_OUT-1:0]       out_valid;

  modport master (
    output in_data, in_valid, cfg_we, cfg_port, cfg_sel, cfg_commit,
    input  cfg_err, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, cfg_we, cfg_port, cfg_sel, cfg_commit,
    output cfg_err, out_data, out_valid
  );
endinterface

// File: rtl/spdu_xbar.sv
// Registered NUM_IN x NUM_OUT crossbar with double-buffered (shadow/active) selects.
// Define SPDU_XBAR_PIPE_EN to add a second output register stage (latency 2).
module spdu_xbar #(
  parameter int unsigned NUM_IN  = 4,
  parameter int unsigned NUM_OUT = 4,
  parameter int unsigned WIDTH   = 1
) (
  input  logic          clk,
  input  logic          reset,
  spdu_xbar_if.slave    bus
);
  localparam int unsigned SEL_W  = $clog2(NUM_IN);
  localparam int unsigned PORT_W = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

  logic [SEL_W-1:0]         shadow_q [NUM_OUT];
  logic [SEL_W-1:0]         shadow_d [NUM_OUT];
  logic [SEL_W-1:0]         active_q [NUM_OUT];
  logic [SEL_W-1:0]         active_d [NUM_OUT];
  logic                     cfg_ok_c;
  logic                     cfg_err_q, cfg_err_d;
  logic [NUM_OUT*WIDTH-1:0] data_q, data_d;
  logic [NUM_OUT-1:0]       valid_q, valid_d;

  // Config decode, shadow/active update and routing of the current active map.
  always_comb begin
    cfg_ok_c  = (32'(bus.cfg_port) < NUM_OUT) && (32'(bus.cfg_sel) < NUM_IN);
    cfg_err_d = bus.cfg_we && !cfg_ok_c;
    shadow_d  = shadow_q;
    active_d  = active_q;
    data_d    = '0;
    valid_d   = '0;
    if (bus.cfg_we && cfg_ok_c) begin
      shadow_d[bus.cfg_port] = bus.cfg_sel;
    end
    // A valid write in the commit cycle is folded into the committed map.
    if (bus.cfg_commit) begin
      active_d = shadow_d;
    end
    for (int j = 0; j < NUM_OUT; j++) begin
      data_d[j*WIDTH +: WIDTH] = bus.in_data[int'(active_q[j])*WIDTH +: WIDTH];
      valid_d[j]               = bus.in_valid[active_q[j]];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int j = 0; j < NUM_OUT; j++) begin
        shadow_q[j] <= SEL_W'(j % NUM_IN);
        active_q[j] <= SEL_W'(j % NUM_IN);
      end
      cfg_err_q <= 1'b0;
      data_q    <= '0;
      valid_q   <= '0;
    end else begin
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      cfg_err_q <= cfg_err_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
    end
  end

  assign bus.cfg_err = cfg_err_q;

`ifdef SPDU_XBAR_PIPE_EN
  logic [NUM_OUT*WIDTH-1:0] data2_q;
  logic [NUM_OUT-1:0]       valid2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      data2_q  <= '0;
      valid2_q <= '0;
    end else begin
      data2_q  <= data_q;
      valid2_q <= valid_q;
    end
  end

  assign bus.out_data  = data2_q;
  assign bus.out_valid = valid2_q;
`else
  assign bus.out_data  = data_q;
  assign bus.out_valid = valid_q;
`endif

endmodule

// File: tb/tb_spdu_xbar.sv
// Scoreboard bench for spdu_xbar: a 4x4 and a 3x4 instance (WIDTH=8) share stimulus.
// Expected outputs are pushed per edge from a behavioural model and popped at the DUT latency.
module tb_spdu_xbar;
`ifdef SPDU_XBAR_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  valid;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic        cfg_we;
  logic [1:0]  cfg_port;
  logic [1:0]  cfg_sel;
  logic        cfg_commit;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  spdu_xbar_if #(.NUM_IN(4), .NUM_OUT(4), .WIDTH(8)) if0 ();
  spdu_xbar_if #(.NUM_IN(3), .NUM_OUT(4), .WIDTH(8)) if1 ();

  assign if0.in_data    = in_data;
  assign if0.in_valid   = in_valid;
  assign if0.cfg_we     = cfg_we;
  assign if0.cfg_port   = cfg_port;
  assign if0.cfg_sel    = cfg_sel;
  assign if0.cfg_commit = cfg_commit;
  assign if1.in_data    = in_data[23:0];
  assign if1.in_valid   = in_valid[2:0];
  assign if1.cfg_we     = cfg_we;
  assign if1.cfg_port   = cfg_port;
  assign if1.cfg_sel    = cfg_sel;
  assign if1.cfg_commit = cfg_commit;

  spdu_xbar #(.NUM_IN(4), .NUM_OUT(4), .WIDTH(8)) dut0 (
    .clk(clk), .reset(reset), .bus(if0.slave)
  );
  spdu_xbar #(.NUM_IN(3), .NUM_OUT(4), .WIDTH(8)) dut1 (
    .clk(clk), .reset(reset), .bus(if1.slave)
  );

  // Behavioural model state, one slot per DUT
  int         m_ni [2] = '{4, 3};
  logic [1:0] m_sh [2][4];
  logic [1:0] m_ac [2][4];
  logic       m_err[2];
  exp_t       q0[$];
  exp_t       q1[$];
  exp_t       cur0, cur1;

  task automatic model_edge(input int d);
    exp_t       e;
    logic [1:0] nsh [4];
    logic       ok;
    if (reset) begin
      for (int j = 0; j < 4; j++) begin
        m_sh[d][j] = 2'(j % m_ni[d]);
        m_ac[d][j] = 2'(j % m_ni[d]);
      end
      m_err[d] = 1'b0;
      if (d == 0) begin
        q0.delete();
        for (int k = 0; k < LAT; k++) q0.push_back('0);
      end else begin
        q1.delete();
        for (int k = 0; k < LAT; k++) q1.push_back('0);
      end
    end else begin
      for (int j = 0; j < 4; j++) begin
        e.data[j*8 +: 8] = in_data[int'(m_ac[d][j])*8 +: 8];
        e.valid[j]       = in_valid[m_ac[d][j]];
      end
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
      ok       = (int'(cfg_sel) < m_ni[d]);
      m_err[d] = cfg_we && !ok;
      nsh      = m_sh[d];
      if (cfg_we && ok) nsh[cfg_port] = cfg_sel;
      m_sh[d] = nsh;
      if (cfg_commit) m_ac[d] = nsh;
    end
    if (d == 0) cur0 = q0.pop_front();
    else        cur1 = q1.pop_front();
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_data = 32'h33221100; in_valid = 4'hf;
    cfg_we = 1'b1; cfg_port = 2'd0; cfg_sel = 2'd3; cfg_commit = 1'b1;
    cycle();
    tests_run++;
    if ({if0.out_data, if0.out_valid, if0.cfg_err} !== 37'h0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %h/%b/%b want 0", if0.out_data, if0.out_valid, if0.cfg_err);
    end
    reset = 1'b0; cfg_we = 1'b0; cfg_commit = 1'b0;
    for (int k = 0; k < LAT; k++) begin
      cycle();
      tests_run++;
      if (if0.out_data !== cur0.data || if0.out_valid !== cur0.valid) begin
        tests_failed++;
        $display("FAIL reset_sb[%0d]: got %h/%b want %h/%b", k, if0.out_data, if0.out_valid, cur0.data, cur0.valid);
      end
    end
    tests_run++;
    if (if0.out_data !== 32'h33221100 || if0.out_valid !== 4'hf) begin
      tests_failed++;
      $display("FAIL reset_identity: got %h/%b want 33221100/1111", if0.out_data, if0.out_valid);
    end
  endtask

  task automatic test_shadow();
    cfg_we = 1'b1; cfg_port = 2'd0; cfg_sel = 2'd3;
    cycle();
    cfg_we = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cycle();
      tests_run++;
      if (if0.out_data[7:0] !== 8'h00 || if0.out_data !== cur0.data) begin
        tests_failed++;
        $display("FAIL shadow_isolation[%0d]: got %h want %h (lane0 00)", k, if0.out_data, cur0.data);
      end
    end
    cfg_commit = 1'b1;
    cycle();
    cfg_commit = 1'b0;
    tests_run++;
    if (if0.out_data[7:0] !== 8'h00) begin
      tests_failed++;
      $display("FAIL commit_edge_old_map: got lane0 %h want 00", if0.out_data[7:0]);
    end
    for (int k = 0; k < LAT; k++) begin
      cycle();
      tests_run++;
      if (if0.out_data !== cur0.data) begin
        tests_failed++;
        $display("FAIL commit_sb[%0d]: got %h want %h", k, if0.out_data, cur0.data);
      end
    end
    tests_run++;
    if (if0.out_data !== 32'h33221133) begin
      tests_failed++;
      $display("FAIL commit_new_map: got %h want 33221133", if0.out_data);
    end
  endtask

  task automatic test_broadcast();
    in_valid = 4'b0100;
    for (int p = 0; p < 3; p++) begin
      cfg_we = 1'b1; cfg_port = 2'(p); cfg_sel = 2'd2;
      cycle();
      tests_run++;
      if (if0.out_data !== cur0.data || if0.out_valid !== cur0.valid) begin
        tests_failed++;
        $display("FAIL bcast_pre[%0d]: got %h/%b want %h/%b", p, if0.out_data, if0.out_valid, cur0.data, cur0.valid);
      end
    end
    cfg_port = 2'd3; cfg_commit = 1'b1;
    cycle();
    cfg_we = 1'b0; cfg_commit = 1'b0;
    for (int k = 0; k < LAT; k++) cycle();
    tests_run++;
    if (if0.out_data !== 32'h22222222 || if0.out_valid !== 4'hf) begin
      tests_failed++;
      $display("FAIL broadcast: got %h/%b want 22222222/1111", if0.out_data, if0.out_valid);
    end
    tests_run++;
    if (if0.out_data !== cur0.data || if0.out_valid !== cur0.valid) begin
      tests_failed++;
      $display("FAIL broadcast_sb: got %h/%b want %h/%b", if0.out_data, if0.out_valid, cur0.data, cur0.valid);
    end
  endtask

  task automatic test_error();
    reset = 1'b1; in_valid = 4'hf;
    cycle();
    reset = 1'b0;
    cfg_we = 1'b1; cfg_port = 2'd1; cfg_sel = 2'd3;
    cycle();
    cfg_we = 1'b0;
    tests_run++;
    if (if1.cfg_err !== 1'b1 || if1.cfg_err !== m_err[1]) begin
      tests_failed++;
      $display("FAIL err_pulse: got %b want 1", if1.cfg_err);
    end
    tests_run++;
    if (if0.cfg_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL err_in_range_sel3: got %b want 0", if0.cfg_err);
    end
    cfg_commit = 1'b1;
    cycle();
    cfg_commit = 1'b0;
    tests_run++;
    if (if1.cfg_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL err_one_cycle: got %b want 0", if1.cfg_err);
    end
    for (int k = 0; k < LAT; k++) cycle();
    tests_run++;
    if (if1.out_data !== 32'h00221100 || if1.out_data !== cur1.data) begin
      tests_failed++;
      $display("FAIL err_map_kept: got %h want 00221100 (model %h)", if1.out_data, cur1.data);
    end
    tests_run++;
    if (if0.out_data !== 32'h33223300 || if0.out_data !== cur0.data) begin
      tests_failed++;
      $display("FAIL sel3_accepted: got %h want 33223300 (model %h)", if0.out_data, cur0.data);
    end
  endtask

  task automatic test_reset_mid();
    cfg_we = 1'b1; cfg_port = 2'd0; cfg_sel = 2'd1;
    cycle();
    cfg_port = 2'd2; cfg_sel = 2'd0;
    cycle();
    cfg_we = 1'b0; reset = 1'b1;
    cycle();
    tests_run++;
    if (if0.out_data !== 32'h0 || if0.out_valid !== 4'h0) begin
      tests_failed++;
      $display("FAIL reset_mid_zero: got %h/%b want 0/0", if0.out_data, if0.out_valid);
    end
    reset = 1'b0; cfg_commit = 1'b1;
    cycle();
    cfg_commit = 1'b0;
    for (int k = 0; k < LAT; k++) cycle();
    tests_run++;
    if (if0.out_data !== 32'h33221100 || if0.out_data !== cur0.data) begin
      tests_failed++;
      $display("FAIL reset_mid_identity: got %h want 33221100 (model %h)", if0.out_data, cur0.data);
    end
  endtask

  task automatic test_back_to_back();
    int errs = 0;
    for (int k = 0; k < 300; k++) begin
      in_data    = $urandom;
      in_valid   = 4'($urandom);
      cfg_we     = ($urandom_range(0, 2) == 0);
      cfg_port   = 2'($urandom);
      cfg_sel    = 2'($urandom);
      cfg_commit = ($urandom_range(0, 4) == 0);
      reset      = ($urandom_range(0, 60) == 0);
      cycle();
      if (if0.out_data !== cur0.data || if0.out_valid !== cur0.valid || if0.cfg_err !== m_err[0]) begin
        errs++;
        if (errs < 5) $display("FAIL random_dut0[%0d]: got %h/%b/%b want %h/%b/%b", k,
          if0.out_data, if0.out_valid, if0.cfg_err, cur0.data, cur0.valid, m_err[0]);
      end
      if (if1.out_data !== cur1.data || if1.out_valid[2:0] !== 3'(cur1.valid) ||
          if1.out_valid[3] !== cur1.valid[3] || if1.cfg_err !== m_err[1]) begin
        errs++;
        if (errs < 5) $display("FAIL random_dut1[%0d]: got %h/%b/%b want %h/%b/%b", k,
          if1.out_data, if1.out_valid, if1.cfg_err, cur1.data, cur1.valid, m_err[1]);
      end
    end
    reset = 1'b0; cfg_we = 1'b0; cfg_commit = 1'b0;
    tests_run++;
    if (errs != 0) begin
      tests_failed++;
      $display("FAIL random_scoreboard: got %0d mismatching cycles want 0", errs);
    end
  endtask

  initial begin
    reset = 1'b1; in_data = '0; in_valid = '0;
    cfg_we = 1'b0; cfg_port = '0; cfg_sel = '0; cfg_commit = 1'b0;
    test_reset();
    test_shadow();
    test_broadcast();
    in_data = 32'h33221100;
    test_error();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
